// File: rtl/otbn_dmem_resp.sv
// otbn_dmem_resp: OTBN data memory with a single-cycle registered read
// response path, per-word valid tracking and a row-by-row wipe engine.
// DmemSizeByte must be a power of two and at least two rows (64 bytes).
module otbn_dmem_resp #(
  parameter int DmemSizeByte = 512,
  localparam int BaseIntgWidth = 39,
  localparam int BaseWordsPerWLEN = 8,
  localparam int ExtWLEN = BaseIntgWidth * BaseWordsPerWLEN,
  localparam int DmemAddrWidth = (DmemSizeByte <= 1) ? 1 : $clog2(DmemSizeByte)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        dmem_req_i,
  input  logic                        dmem_write_i,
  input  logic [DmemAddrWidth-1:0]    dmem_addr_i,
  input  logic [ExtWLEN-1:0]          dmem_wdata_i,
  input  logic [ExtWLEN-1:0]          dmem_wmask_i,
  input  logic [BaseWordsPerWLEN-1:0] dmem_rmask_i,
  output logic [ExtWLEN-1:0]          dmem_rdata_o,
  output logic                        dmem_rvalid_o,
  output logic                        dmem_rerror_o,
  input  logic                        wipe_req_i,
  output logic                        wipe_busy_o,
  output logic                        wipe_done_o
);

  localparam int NumRows     = DmemSizeByte / 32;
  localparam int RowIdxWidth = DmemAddrWidth - 5;
  localparam int CntWidth    = (NumRows <= 1) ? 1 : $clog2(NumRows);
  localparam logic [CntWidth-1:0] LastRow = CntWidth'(NumRows - 1);

  typedef enum logic {
    IDLE,
    WIPE
  } state_e;

  state_e                      state_q, state_d;
  logic [CntWidth-1:0]         wipe_cnt_q, wipe_cnt_d;
  logic                        done_q, done_d;
  logic                        wipe_en;
  logic                        wr_en;
  logic                        rd_req;
  logic [RowIdxWidth-1:0]      row;
  logic [ExtWLEN-1:0]          mem_q [NumRows];
  logic [BaseWordsPerWLEN-1:0] valid_q [NumRows];
  logic [BaseWordsPerWLEN-1:0] wr_valid;
  logic [ExtWLEN-1:0]          rdata_d, rdata_q;
  logic                        rerror_d, rerror_q;
  logic                        rvalid_q;
  logic                        unused_addr_bits;

  // The byte offset within a row carries no information for a full-row port.
  assign row              = dmem_addr_i[DmemAddrWidth-1:5];
  assign unused_addr_bits = ^dmem_addr_i[4:0];
  assign rd_req           = dmem_req_i & ~dmem_write_i;

  // Next-state logic: IDLE serves writes and can launch a wipe, WIPE walks the rows.
  always_comb begin
    state_d    = state_q;
    wipe_cnt_d = wipe_cnt_q;
    done_d     = 1'b0;
    wipe_en    = 1'b0;
    wr_en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        wr_en = dmem_req_i & dmem_write_i;
        if (wipe_req_i) begin
          state_d    = WIPE;
          wipe_cnt_d = '0;
        end
      end
      WIPE: begin
        wipe_en    = 1'b1;
        wipe_cnt_d = wipe_cnt_q + 1'b1;
        if (wipe_cnt_q == LastRow) begin
          state_d    = IDLE;
          wipe_cnt_d = '0;
          done_d     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A word becomes valid when the first bit of that word is written.
  always_comb begin
    wr_valid = '0;
    for (int j = 0; j < BaseWordsPerWLEN; j++) begin
      wr_valid[j] = dmem_wmask_i[j*BaseIntgWidth];
    end
  end

  // Masked read data and error flag; a wiping memory answers with zeros and an error.
  always_comb begin
    rdata_d  = '0;
    rerror_d = 1'b0;
    for (int j = 0; j < BaseWordsPerWLEN; j++) begin
      if (dmem_rmask_i[j]) begin
        rdata_d[j*BaseIntgWidth +: BaseIntgWidth] = mem_q[row][j*BaseIntgWidth +: BaseIntgWidth];
        if (!valid_q[row][j]) begin
          rerror_d = 1'b1;
        end
      end
    end
    if (state_q == WIPE) begin
      rdata_d  = '0;
      rerror_d = 1'b1;
    end
  end

  // State register, wipe row counter and the completion pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      wipe_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wipe_cnt_q <= wipe_cnt_d;
      done_q     <= done_d;
    end
  end

  // Read response registers; data and error hold between responses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rerror_q <= 1'b0;
    end else begin
      rvalid_q <= rd_req;
      if (rd_req) begin
        rdata_q  <= rdata_d;
        rerror_q <= rerror_d;
      end
    end
  end

  // Word valid bits are cleared by reset so stale data always reads back with an error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < NumRows; r++) begin
        valid_q[r] <= '0;
      end
    end else if (wipe_en) begin
      valid_q[wipe_cnt_q] <= '0;
    end else if (wr_en) begin
      valid_q[row] <= valid_q[row] | wr_valid;
    end
  end

  // Data array has no reset; the wipe engine or bitwise-masked writes update it.
  always_ff @(posedge clk_i) begin
    if (wipe_en) begin
      mem_q[wipe_cnt_q] <= '0;
    end else if (wr_en) begin
      mem_q[row] <= (mem_q[row] & ~dmem_wmask_i) | (dmem_wdata_i & dmem_wmask_i);
    end
  end

  assign dmem_rdata_o  = rdata_q;
  assign dmem_rvalid_o = rvalid_q;
  assign dmem_rerror_o = rerror_q;
  assign wipe_busy_o   = (state_q == WIPE);
  assign wipe_done_o   = done_q;

endmodule

// File: tb/tb_otbn_dmem_resp.sv
// tb_otbn_dmem_resp: randomized and directed stimulus against a word-level
// memory model; expected responses are queued and checked by a monitor.
module tb_otbn_dmem_resp;

  localparam int DmemSizeByte = 512;
  localparam int W            = 39;
  localparam int NW           = 8;
  localparam int ExtWLEN      = W * NW;
  localparam int AW           = 9;
  localparam int NumRows      = DmemSizeByte / 32;

  typedef struct {
    int                 due;
    logic [ExtWLEN-1:0] data;
    logic [ExtWLEN-1:0] care;
    logic               err;
  } resp_t;

  typedef struct {
    int   due;
    logic busy;
    logic done;
  } stat_t;

  logic               clk_i = 1'b0;
  logic               rst_ni = 1'b0;
  logic               dmem_req_i = 1'b0;
  logic               dmem_write_i = 1'b0;
  logic [AW-1:0]      dmem_addr_i = '0;
  logic [ExtWLEN-1:0] dmem_wdata_i = '0;
  logic [ExtWLEN-1:0] dmem_wmask_i = '0;
  logic [NW-1:0]      dmem_rmask_i = '0;
  logic [ExtWLEN-1:0] dmem_rdata_o;
  logic               dmem_rvalid_o;
  logic               dmem_rerror_o;
  logic               wipe_req_i = 1'b0;
  logic               wipe_busy_o;
  logic               wipe_done_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int busy_seen = 0;
  int done_seen = 0;

  resp_t resp_q[$];
  stat_t stat_q[$];
  logic [ExtWLEN-1:0] last_data = '0;
  logic [ExtWLEN-1:0] last_care = '1;

  // Reference model: word contents, which bits are known, word validity, wipe progress.
  logic [W-1:0] m_data  [NumRows][NW];
  logic [W-1:0] m_known [NumRows][NW];
  logic         m_valid [NumRows][NW];
  logic         m_wipe = 1'b0;
  int           m_row = 0;

  otbn_dmem_resp #(.DmemSizeByte(DmemSizeByte)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .dmem_req_i    (dmem_req_i),
    .dmem_write_i  (dmem_write_i),
    .dmem_addr_i   (dmem_addr_i),
    .dmem_wdata_i  (dmem_wdata_i),
    .dmem_wmask_i  (dmem_wmask_i),
    .dmem_rmask_i  (dmem_rmask_i),
    .dmem_rdata_o  (dmem_rdata_o),
    .dmem_rvalid_o (dmem_rvalid_o),
    .dmem_rerror_o (dmem_rerror_o),
    .wipe_req_i    (wipe_req_i),
    .wipe_busy_o   (wipe_busy_o),
    .wipe_done_o   (wipe_done_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "[TB] watchdog");
  end

  // Monitor: every cycle check rvalid against the queue, data against the held value, status.
  always @(negedge clk_i) begin
    logic  exp_v;
    resp_t r;
    stat_t s;
    if (wipe_busy_o === 1'b1) busy_seen++;
    if (wipe_done_o === 1'b1) done_seen++;
    if (rst_ni) begin
      exp_v = (resp_q.size() > 0) && (resp_q[0].due == cyc);
      checks++;
      if (dmem_rvalid_o !== exp_v) begin
        errors++;
        $display("[TB] FAIL rvalid cyc=%0d actual=%b required=%b", cyc, dmem_rvalid_o, exp_v);
      end
      if (exp_v) begin
        r = resp_q.pop_front();
        last_data = r.data;
        last_care = r.care;
        checks++;
        if (dmem_rerror_o !== r.err) begin
          errors++;
          $display("[TB] FAIL rerror cyc=%0d actual=%b required=%b", cyc, dmem_rerror_o, r.err);
        end
      end
      checks++;
      if (((dmem_rdata_o ^ last_data) & last_care) !== '0) begin
        errors++;
        $display("[TB] FAIL rdata cyc=%0d actual=%h required=%h", cyc, dmem_rdata_o & last_care, last_data & last_care);
      end
      if (stat_q.size() > 0 && stat_q[0].due == cyc) begin
        s = stat_q.pop_front();
        checks++;
        if (wipe_busy_o !== s.busy || wipe_done_o !== s.done) begin
          errors++;
          $display("[TB] FAIL status cyc=%0d actual busy=%b done=%b required busy=%b done=%b",
                   cyc, wipe_busy_o, wipe_done_o, s.busy, s.done);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [ExtWLEN-1:0] actual,
                             input logic [ExtWLEN-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Model of one clock edge: queue the read answer, then apply wipe or write effects.
  task automatic modelStep(input logic req, input logic write, input logic [AW-1:0] addr,
                           input logic [ExtWLEN-1:0] wdata, input logic [ExtWLEN-1:0] wmask,
                           input logic [NW-1:0] rmask, input logic wipe);
    int    r;
    logic  d;
    resp_t e;
    stat_t s;
    logic [W-1:0] wm;
    r = int'(addr[AW-1:5]);
    d = 1'b0;
    if (req && !write) begin
      e.due  = cyc + 1;
      e.data = '0;
      e.care = '1;
      e.err  = 1'b0;
      if (m_wipe) begin
        e.err = 1'b1;
      end else begin
        for (int j = 0; j < NW; j++) begin
          if (rmask[j]) begin
            e.data[j*W +: W] = m_data[r][j];
            e.care[j*W +: W] = m_known[r][j];
            if (!m_valid[r][j]) e.err = 1'b1;
          end
        end
      end
      resp_q.push_back(e);
    end
    if (m_wipe) begin
      for (int j = 0; j < NW; j++) begin
        m_data[m_row][j]  = '0;
        m_known[m_row][j] = '1;
        m_valid[m_row][j] = 1'b0;
      end
      if (m_row == NumRows - 1) begin
        m_wipe = 1'b0;
        d = 1'b1;
      end else begin
        m_row++;
      end
    end else begin
      if (req && write) begin
        for (int j = 0; j < NW; j++) begin
          wm = wmask[j*W +: W];
          m_data[r][j]  = (m_data[r][j] & ~wm) | (wdata[j*W +: W] & wm);
          m_known[r][j] = m_known[r][j] | wm;
          if (wm[0]) m_valid[r][j] = 1'b1;
        end
      end
      if (wipe) begin
        m_wipe = 1'b1;
        m_row  = 0;
      end
    end
    s.due  = cyc + 1;
    s.busy = m_wipe;
    s.done = d;
    stat_q.push_back(s);
  endtask

  task automatic applyStimulus(input logic req, input logic write, input logic [AW-1:0] addr,
                               input logic [ExtWLEN-1:0] wdata, input logic [ExtWLEN-1:0] wmask,
                               input logic [NW-1:0] rmask, input logic wipe);
    dmem_req_i   = req;
    dmem_write_i = write;
    dmem_addr_i  = addr;
    dmem_wdata_i = wdata;
    dmem_wmask_i = wmask;
    dmem_rmask_i = rmask;
    wipe_req_i   = wipe;
    modelStep(req, write, addr, wdata, wmask, rmask, wipe);
    @(posedge clk_i);
    #1;
  endtask

  task automatic opIdle();
    applyStimulus(1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
  endtask

  task automatic opWrite(input logic [AW-1:0] addr, input logic [ExtWLEN-1:0] wdata,
                         input logic [ExtWLEN-1:0] wmask, input logic wipe);
    applyStimulus(1'b1, 1'b1, addr, wdata, wmask, '0, wipe);
  endtask

  task automatic opRead(input logic [AW-1:0] addr, input logic [NW-1:0] rmask, input logic wipe);
    applyStimulus(1'b1, 1'b0, addr, '0, '0, rmask, wipe);
  endtask

  // Asynchronous reset in mid-cycle; outputs must clear before the next edge.
  task automatic doReset();
    #1;
    rst_ni = 1'b0;
    #1;
    checkOutput("reset_rdata", dmem_rdata_o, '0);
    checkOutput("reset_rvalid", ExtWLEN'(dmem_rvalid_o), '0);
    checkOutput("reset_rerror", ExtWLEN'(dmem_rerror_o), '0);
    checkOutput("reset_busy", ExtWLEN'(wipe_busy_o), '0);
    checkOutput("reset_done", ExtWLEN'(wipe_done_o), '0);
    resp_q.delete();
    stat_q.delete();
    last_data = '0;
    last_care = '1;
    m_wipe = 1'b0;
    m_row  = 0;
    for (int r = 0; r < NumRows; r++)
      for (int j = 0; j < NW; j++) m_valid[r][j] = 1'b0;
    dmem_req_i = 1'b0;
    wipe_req_i = 1'b0;
    repeat (2) begin
      @(posedge clk_i);
      #1;
      checkOutput("reset_hold_done", ExtWLEN'(wipe_done_o), '0);
    end
    rst_ni = 1'b1;
  endtask

  function automatic logic [ExtWLEN-1:0] randExt();
    logic [319:0] t;
    for (int k = 0; k < 10; k++) t[k*32 +: 32] = $urandom;
    return t[ExtWLEN-1:0];
  endfunction

  function automatic logic [ExtWLEN-1:0] randMask();
    logic [ExtWLEN-1:0] m;
    logic [63:0]        t;
    m = '0;
    for (int j = 0; j < NW; j++) begin
      t = {$urandom, $urandom};
      case ($urandom_range(0, 2))
        0:       m[j*W +: W] = '0;
        1:       m[j*W +: W] = '1;
        default: m[j*W +: W] = t[W-1:0];
      endcase
    end
    return m;
  endfunction

  initial begin
    logic [ExtWLEN-1:0] wd;
    logic [ExtWLEN-1:0] wm;
    logic [AW-1:0]      a;
    int                 sel;
    for (int r = 0; r < NumRows; r++)
      for (int j = 0; j < NW; j++) begin
        m_data[r][j]  = '0;
        m_known[r][j] = '0;
        m_valid[r][j] = 1'b0;
      end

    $display("[TB] reset and invalid-word errors");
    doReset();
    opRead(9'h040, 8'hFF, 1'b0);
    wm = '0;
    wm[0 +: W] = '1;
    opWrite(9'h040, randExt(), wm, 1'b0);
    opRead(9'h040, 8'h01, 1'b0);
    opRead(9'h05C, 8'h03, 1'b0);

    $display("[TB] write then read word3");
    wd = randExt();
    wd[3*W +: W] = {7'h5A, 32'h12345678};
    opWrite(9'h020, wd, '1, 1'b0);
    opRead(9'h020, 8'h08, 1'b0);

    $display("[TB] alternating write/read over all rows");
    for (int r = 0; r < NumRows; r++) begin
      a = AW'(r * 32);
      opWrite(a, randExt(), '1, 1'b0);
      opRead(a, 8'hFF, 1'b0);
    end

    $display("[TB] randomized traffic");
    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 39);
      a   = AW'($urandom_range(0, DmemSizeByte - 1));
      if (sel < 18)      opRead(a, NW'($urandom_range(0, 255)), 1'b0);
      else if (sel < 36) opWrite(a, randExt(), randMask(), 1'b0);
      else if (sel < 39) opIdle();
      else if (sel[0])   opRead(a, NW'($urandom_range(1, 255)), 1'b1);
      else               opWrite(a, randExt(), '1, 1'b1);
    end
    while (m_wipe) opIdle();

    $display("[TB] full wipe with accesses during the wipe");
    for (int r = 0; r < NumRows; r++) opWrite(AW'(r * 32), randExt(), '1, 1'b0);
    opIdle();
    busy_seen = 0;
    done_seen = 0;
    opIdle();
    applyStimulus(1'b0, 1'b0, '0, '0, '0, '0, 1'b1);
    for (int k = 0; k < 5; k++) opIdle();
    opRead(9'h140, 8'hFF, 1'b0);
    opWrite(9'h040, randExt(), '1, 1'b1);
    for (int k = 0; k < 30 && m_wipe; k++) opIdle();
    checkOutput("wipe_ended", ExtWLEN'(m_wipe), '0);
    opIdle();
    opIdle();
    checkOutput("wipe_busy_cycles", ExtWLEN'(busy_seen), ExtWLEN'(NumRows));
    checkOutput("wipe_done_pulses", ExtWLEN'(done_seen), ExtWLEN'(1));
    for (int r = 0; r < NumRows; r++) opRead(AW'(r * 32 + 4), 8'hFF, 1'b0);

    $display("[TB] reset during wipe");
    for (int r = 0; r < NumRows; r++) opWrite(AW'(r * 32), randExt(), '1, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, '0, '0, '0, 1'b1);
    for (int k = 0; k < 8; k++) opIdle();
    done_seen = 0;
    doReset();
    for (int r = 0; r < NumRows; r++) opRead(AW'(r * 32), 8'hFF, 1'b0);
    opIdle();
    opIdle();
    checkOutput("abort_done_pulses", ExtWLEN'(done_seen), '0);
    checkOutput("pending_responses", ExtWLEN'(resp_q.size()), '0);

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
